// File: rtl/mux2_tree_rr_arb_pkg.sv
// Shared types and tree arithmetic for the 2:1 mux tree and its drivers.
// The tree has 2*N-1 nodes; inputs are nodes 0..N-1 and the root is the last node.
package mux2_tree_rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int node_count(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int root_node(input int n);
        return 2 * n - 2;
    endfunction

    // First mux index of tree level l (level 0 sits on the inputs).
    function automatic int level_base(input int n, input int l);
        return n - (n >> l);
    endfunction

endpackage

// File: rtl/mux2_tree_sel_enc.sv
// Combinational index -> per-mux select vector for a binary 2:1 mux tree.
// Each level l steers mux base(l) + (idx >> (l+1)) with bit idx[l].
module mux2_tree_sel_enc
    import mux2_tree_rr_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    localparam int IDX_W = clog2(NUM_INPUTS)
) (
    input  logic [IDX_W-1:0]      idx,
    output logic [NUM_INPUTS-2:0] sels
);

    always_comb begin
        sels = '0;
        for (int l = 0; l < IDX_W; l++) begin
            for (int j = 0; j < NUM_INPUTS - 1; j++) begin
                if (j == level_base(NUM_INPUTS, l) + (int'(idx) >> (l + 1))) begin
                    sels[j] = ((int'(idx) >> l) & 1) != 0;
                end
            end
        end
    end

endmodule

// File: rtl/mux2_tree_rr_arb.sv
// Round-robin arbiter driving a 2:1 mux tree select vector.
// Grant is held under valid/ready; the pointer advances past the winner on transfer.
module mux2_tree_rr_arb
    import mux2_tree_rr_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    localparam int IDX_W = clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic                  out_ready,
    output logic [NUM_INPUTS-2:0] sels,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  out_valid,
    output logic [NUM_INPUTS-1:0] ack
);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [NUM_INPUTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [NUM_INPUTS-2:0] sels_q, sels_d;

    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      cand;
    logic [NUM_INPUTS-2:0] pick_sels;
    logic                  xfer;

    // Descending scan so the requester nearest to ptr wins; index math wraps
    // naturally because NUM_INPUTS is a power of two.
    always_comb begin
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            cand = ptr_q + IDX_W'(i);
            if (req[cand]) pick_idx = cand;
        end
    end

    mux2_tree_sel_enc #(
        .NUM_INPUTS(NUM_INPUTS)
    ) u_sel_enc (
        .idx  (pick_idx),
        .sels (pick_sels)
    );

    assign xfer = (state_q == GRANT) && out_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        sels_d      = sels_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    grant_d     = NUM_INPUTS'(1) << pick_idx;
                    grant_idx_d = pick_idx;
                    sels_d      = pick_sels;
                end
            end
            GRANT: begin
                if (xfer) begin
                    state_d     = IDLE;
                    ptr_d       = grant_idx_q + IDX_W'(1);
                    grant_d     = '0;
                    grant_idx_d = '0;
                    sels_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            sels_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            sels_q      <= sels_d;
        end
    end

    assign out_valid = (state_q == GRANT);
    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign sels      = sels_q;
    assign ack       = xfer ? grant_q : '0;

endmodule
